// File: rtl/key_pkg.sv
// Shared key-path definitions: click FSM state encoding and the default
// click window length for a 50 MHz system clock.
package key_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT2 = 2'd1;
  localparam logic [1:0] ST_WAIT3 = 2'd2;

  // 500 ms at 50 MHz, expressed as cycle count minus one
  localparam logic [24:0] KEY_WIN_MAX_50M = 25'd24_999_999;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT2 = ST_WAIT2,
    S_WAIT3 = ST_WAIT3
  } click_state_t;

endpackage

// File: rtl/click_win_timer.sv
// Click window timer: synchronous clear, enable, saturating up-count;
// done flags the last cycle of the window.
module click_win_timer #(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] WIN_MAX = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != WIN_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == WIN_MAX);

endmodule

// File: rtl/key_click_decoder.sv
// Classifies bursts of debounced key presses into single/double/triple clicks.
// Optional feature macro: CLICK_TRIPLE_EN (enables WAIT3 and click_triple).
module key_click_decoder
  import key_pkg::*;
#(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] WIN_MAX = CNT_W'(KEY_WIN_MAX_50M)
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic key_pulse,
  output logic click_single,
  output logic click_double,
  output logic click_triple,
  output logic busy
);

  click_state_t state;
  logic         key_d;
  logic         press;
  logic         win_done;
  logic         win_clr;

  // A held input only counts once, on its rising edge
  assign press   = key_pulse & ~key_d;
  assign busy    = (state != S_IDLE);
  assign win_clr = press | (state == S_IDLE);

  click_win_timer #(
    .CNT_W   (CNT_W),
    .WIN_MAX (WIN_MAX)
  ) u_timer (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .clr   (win_clr),
    .en    (busy),
    .done  (win_done)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      key_d        <= 1'b0;
      click_single <= 1'b0;
      click_double <= 1'b0;
`ifdef CLICK_TRIPLE_EN
      click_triple <= 1'b0;
`endif
    end else begin
      key_d        <= key_pulse;
      click_single <= 1'b0;
      click_double <= 1'b0;
`ifdef CLICK_TRIPLE_EN
      click_triple <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (press) state <= S_WAIT2;
        end
        S_WAIT2: begin
          // A press on the last window cycle still belongs to the burst
          if (press) begin
`ifdef CLICK_TRIPLE_EN
            state <= S_WAIT3;
`else
            click_double <= 1'b1;
            state        <= S_IDLE;
`endif
          end else if (win_done) begin
            click_single <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_WAIT3: begin
`ifdef CLICK_TRIPLE_EN
          if (press) begin
            click_triple <= 1'b1;
            state        <= S_IDLE;
          end else if (win_done) begin
            click_double <= 1'b1;
            state        <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef CLICK_TRIPLE_EN
  assign click_triple = 1'b0;
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// Scoreboard bench for key_click_decoder with a burst-timing reference model.
module tb_key_click_decoder;

  localparam int WIN = 10;
`ifdef CLICK_TRIPLE_EN
  localparam int MAXN = 3;
`else
  localparam int MAXN = 2;
`endif

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_pulse = 1'b0;
  logic click_single, click_double, click_triple, busy;

  key_click_decoder #(
    .CNT_W   (25),
    .WIN_MAX (25'd10)
  ) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .key_pulse    (key_pulse),
    .click_single (click_single),
    .click_double (click_double),
    .click_triple (click_triple),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  exp_busy = 1'b0;

  // Model of the open burst: press count and cycle of its latest press
  int  n_press = 0;
  int  last_press = 0;
  bit  prev_kp = 1'b0;

  task automatic push_ev(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive the inputs for cycle cyc and advance the model
  task automatic step(input bit kp, input bit rst);
    bit press;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (rst) begin
      sys_rst_n = 1'b0;
      key_pulse = 1'b0;
      n_press   = 0;
      prev_kp   = 1'b0;
      exp_busy  = 1'b0;
      exp_q.delete();
      return;
    end
    sys_rst_n = 1'b1;
    key_pulse = kp;
    if (n_press > 0 && cyc == last_press + WIN + 2) begin
      push_ev(cyc, n_press);
      n_press = 0;
    end
    exp_busy = (n_press > 0);
    press = kp && !prev_kp;
    prev_kp = kp;
    if (press) begin
      n_press = n_press + 1;
      last_press = cyc;
      if (n_press == MAXN) begin
        push_ev(cyc + 1, n_press);
        n_press = 0;
      end
    end
  endtask

  task automatic run_pat(input logic [63:0] pat, input int len);
    for (int i = 0; i < len; i++) step(pat[i], 1'b0);
  endtask

  // Monitor: compares busy every cycle and pops one expectation per event pulse
  initial begin
    forever begin
      @(negedge clk);
      total = total + 1;
      if (busy !== exp_busy) begin
        bad = bad + 1;
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, exp_busy);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL missed_event cyc=%0d actual=none required=kind%0d@%0d",
                 cyc, exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (click_single || click_double || click_triple) begin
        int k;
        total = total + 1;
        k = click_triple ? 3 : (click_double ? 2 : 1);
        if ((int'(click_single) + int'(click_double) + int'(click_triple)) != 1) begin
          bad = bad + 1;
          $display("FAIL onehot cyc=%0d actual=%b%b%b required=one_high", cyc,
                   click_single, click_double, click_triple);
        end else if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL spurious_event cyc=%0d actual=kind%0d required=none", cyc, k);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.kind != k) begin
            bad = bad + 1;
            $display("FAIL event cyc=%0d actual=kind%0d required=kind%0d@%0d",
                     cyc, k, e.kind, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int hold;
    int gap;
    int rst_left;
    // Initial reset
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Reset in the middle of an open window discards the burst
    run_pat(64'h1, 4);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_pat(64'h0, 20);

    run_pat(64'h1, 30);    // single
    run_pat(64'h21, 30);   // press at 0 and 5
    run_pat(64'h221, 30);  // press at 0, 5, 9
    run_pat(64'h801, 40);  // second press on the last window cycle
    run_pat(64'hFF, 30);   // held input
    run_pat({32'h0, 32'hFFFF_FFFF}, 60);  // held longer than the window

    // New burst starting in the same cycle as an event pulse
    run_pat(64'h1 | (64'h1 << 12), 40);

    // Randomized bursts with occasional resets
    hold = 0;
    gap = 3;
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_left > 0) begin
        rst_left = rst_left - 1;
        step(1'b0, 1'b1);
      end else if ($urandom_range(0, 399) == 0) begin
        rst_left = $urandom_range(0, 2);
        hold = 0;
        step(1'b0, 1'b1);
      end else if (hold > 0) begin
        hold = hold - 1;
        step(1'b1, 1'b0);
      end else if (gap > 0) begin
        gap = gap - 1;
        step(1'b0, 1'b0);
      end else begin
        hold = $urandom_range(0, 2);
        gap  = $urandom_range(0, 24);
        step(1'b1, 1'b0);
      end
    end
    run_pat(64'h0, 30);

    @(negedge clk);
    #1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
